flux_fifo: RTL and testbench
============================

# flux_fifo

Multi-flux FIFO channel that implements the FIFO side of the `write_interface` / `read_interface` pair used by the HEVC dataflow actors. It holds FLUX independent first-word-fall-through queues behind one write port and one shared read port. It presents to the consuming actor the head of the highest-priority non-empty flux, so actors such as the shifter can pick, read and pop in a single cycle. It sits between a producing actor (or testbench source) and any consuming actor in the HEVC chain.

## Interface
- FLUX, 2: number of independent queues (fluxes); ≥1.
- DATA_WIDTH, 32: word width; must equal the interface `din`/`dout` width.
- DEPTH, 8: words per flux; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_tag  in  $clog2(FLUX) (min 1)  destination flux for the current write.
- write_port  write_interface.fifo  —  `write` in 1, `din` in DATA_WIDTH, `full` out 1.
- read_port  read_interface.fifo  —  `read` in FLUX, `empty` out FLUX, `dout` out DATA_WIDTH.
- err_overflow  out  1  sticky; write attempted while target flux full.
- err_underflow  out  1  sticky; illegal read (empty or non-presented flux).

## Operation
- Per flux: storage DEPTH×DATA_WIDTH, wr_ptr/rd_ptr of $clog2(DEPTH) bits (natural wrap), count of $clog2(DEPTH+1) bits.
- `empty[i]` = (count_i == 0); registered-state-derived, no bypass.
- `full` = (count[wr_tag] == DEPTH); combinational on `wr_tag`, registered state otherwise.
- Write accepted when `write`=1 and `full`=0: store `din` at wr_ptr[wr_tag], increment wr_ptr and count.
- Presented flux sel = highest index i with empty[i]=0; sel=0 if all empty.
- `dout` = head word of flux sel; `'0` when all fluxes empty.
- `read[i]` accepted only when i==sel and empty[i]=0: increment rd_ptr_i, decrement count_i.
- Illegal read (read[i]=1 with i≠sel or empty[i]=1, or more than one read bit set): ignored for state, sets err_underflow.
- Write with full=1: dropped, sets err_overflow.
- Simultaneous accepted write and read on the same flux: count unchanged, both pointers advance.
- Full flux plus read in same cycle: write still rejected (no pass-through); `full` judged on pre-edge count.
- Empty flux plus write in same cycle: read not possible; word visible next cycle.
- Error flags clear only on reset.

## Timing
- Reset: all counts/pointers 0; `empty` all 1; `full` 0; `dout` '0; err flags 0. Storage contents not reset.
- Write-to-visible latency: write accepted at edge N → `empty` deasserts and `dout` valid after edge N (cycle N+1).
- Read: pop at edge N; next head (or new sel) on `dout` in cycle N+1.
- Back-to-back: one write and one read per cycle sustained; no bubbles.
- `dout`, `empty`, `sel` are pure functions of registered state: no combinational path from `read` or `write` to any output; `full` depends combinationally only on `wr_tag`.
- Reset mid-operation: all queued data discarded in one cycle; inputs during reset ignored.

## Structure
- Package `hevc_fifo_pkg`: DATA_WIDTH default, `flux_tag_t` width function, count/pointer width helpers.
- Sub-module `flux_queue`: single FWFT queue (storage, pointers, count, `empty`, `full`, head word); instantiated FLUX times via generate.
- Top: write demux by `wr_tag`, priority encoder for sel, `dout` mux, read legality check, error flags.

## Test plan
- Reset, FLUX=2, DEPTH=8: after rst → empty=2'b11, full=0, dout=0, err flags 0.
- Write 0x11,0x22,0x33 to flux 0; pop each cycle on read[0] → dout 0x11, 0x22, 0x33, then empty[0]=1 and dout=0.
- Write 8 words to flux 1 → full=1 with wr_tag=1, full=0 with wr_tag=0; 9th write dropped, err_overflow=1, count stays 8.
- Flux 0 holds 0xA0, flux 1 holds 0xB0 → dout=0xB0; pop read[1] → next cycle dout=0xA0.
- Flux 1 full; write+read on flux 1 same cycle → write rejected, count 7; steady write+read on half-full flux 0 for 20 cycles → count constant, data order preserved across pointer wrap.
- read[0]=1 while flux 1 presented, and read[1]=1 while flux 1 empty → no state change, err_underflow=1; assert rst mid-stream → all empty next cycle.

Source files
------------

// File: rtl/hevc_fifo_pkg.sv
// Shared constants and width helpers for the HEVC dataflow FIFO channels.
//   DATA_WIDTH_DEF : default word width of the write/read interfaces.
//   tag_width()    : width of a flux tag (at least 1 bit, even for one flux).
//   ptr_width()    : width of a per-flux read/write pointer (natural wrap).
//   cnt_width()    : width of a per-flux occupancy counter (0..DEPTH).
package hevc_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hevc_fifo_if.sv
// Producer-side and consumer-side channel interfaces of the HEVC actors.
//   write_interface : write (in), din (in), full (out) as seen by the FIFO.
//   read_interface  : read[FLUX] (in), empty[FLUX] (out), dout (out) as seen
//                     by the FIFO.
interface write_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  write;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;

  modport fifo  (input write, input din, output full);
  modport actor (output write, output din, input full);
endinterface

interface read_interface #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 32
);
  logic [FLUX-1:0]       read;
  logic [FLUX-1:0]       empty;
  logic [DATA_WIDTH-1:0] dout;

  modport fifo  (input read, output empty, output dout);
  modport actor (output read, input empty, input dout);
endinterface

// File: rtl/flux_queue.sv
// Single first-word-fall-through queue.
//   clk, rst : clock and synchronous active-high reset (pointers/count only).
//   push     : store din this edge (caller guarantees the queue is not full).
//   pop      : drop the head this edge (caller guarantees not empty).
//   din      : write word.
//   head     : word at the read pointer, combinational from registered state.
//   empty    : count == 0.
//   full     : count == DEPTH.
module flux_queue
  import hevc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  // Asynchronous-read storage: the head must be visible in the same cycle
  // the consumer decides to pop, so no read register sits in front of it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/flux_fifo.sv
// Multi-flux FIFO channel: FLUX independent FWFT queues behind one write port
// and one shared read port that presents the highest-index non-empty flux.
//   clk, rst      : clock and synchronous active-high reset.
//   wr_tag        : destination flux of the current write.
//   write_port    : write/din in, full out (full of the flux named by wr_tag).
//   read_port     : read[FLUX] in, empty[FLUX] out, dout out (presented head).
//   err_overflow  : sticky, a write hit a full flux.
//   err_underflow : sticky, a read was not exactly the presented non-empty flux.
module flux_fifo
  import hevc_fifo_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [tag_width(FLUX)-1:0] wr_tag,
  write_interface.fifo             write_port,
  read_interface.fifo              read_port,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int TW = tag_width(FLUX);

  logic [DATA_WIDTH-1:0] head_q [FLUX];
  logic [FLUX-1:0]       empty_q;
  logic [FLUX-1:0]       full_q;
  logic [FLUX-1:0]       push;
  logic [FLUX-1:0]       pop;
  logic [FLUX-1:0]       sel_onehot;
  logic [TW-1:0]         sel;
  logic                  full;
  logic                  read_ok;
  logic                  err_overflow_reg;
  logic                  err_underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_flux
      assign push[gi] = write_port.write && !full && (wr_tag == TW'(gi));
      assign pop[gi]  = read_ok && read_port.read[gi];

      flux_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (write_port.din),
        .head  (head_q[gi]),
        .empty (empty_q[gi]),
        .full  (full_q[gi])
      );
    end
  endgenerate

  // A tag that names no existing flux (non-power-of-two FLUX) reads as full,
  // so such writes are dropped and flagged rather than lost silently.
  always_comb begin
    full = 1'b1;
    if (int'(wr_tag) < FLUX) full = full_q[wr_tag];
  end

  // Priority encoder: ascending scan so the highest non-empty index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (!empty_q[i]) sel = TW'(i);
    end
  end

  // A read is legal only as a single bit on the presented, non-empty flux.
  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
    read_ok         = (read_port.read == sel_onehot) && !empty_q[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (write_port.write && full)       err_overflow_reg  <= 1'b1;
      if ((|read_port.read) && !read_ok)  err_underflow_reg <= 1'b1;
    end
  end

  assign write_port.full = full;
  assign read_port.empty = empty_q;
  assign read_port.dout  = (&empty_q) ? '0 : head_q[sel];
  assign err_overflow    = err_overflow_reg;
  assign err_underflow   = err_underflow_reg;

endmodule

// File: tb/tb_flux_fifo.sv
// Directed self-checking bench for flux_fifo (FLUX=2, DATA_WIDTH=32, DEPTH=8).
module tb_flux_fifo;
  import hevc_fifo_pkg::*;

  localparam int FLUX = 2;
  localparam int DW   = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic [0:0] wr_tag;
  logic err_overflow;
  logic err_underflow;

  int checks = 0;
  int errors = 0;

  write_interface #(.DATA_WIDTH(DW)) wp ();
  read_interface  #(.FLUX(FLUX), .DATA_WIDTH(DW)) rp ();

  flux_fifo #(
    .FLUX       (FLUX),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_tag        (wr_tag),
    .write_port    (wp),
    .read_port     (rp),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=%h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wp.write = 1'b0;
    rp.read  = '0;
  endtask

  task automatic wr(input logic tag, input logic [31:0] data);
    wr_tag   = tag;
    wp.din   = data;
    wp.write = 1'b1;
    tick();
    wp.write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] bits);
    rp.read = bits;
    tick();
    rp.read = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_tag = 1'b0;
    wp.din = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_empty", 32'(rp.empty), 32'h3);
    check("rst_full", 32'(wp.full), 32'h0);
    check("rst_dout", rp.dout, 32'h0);
    check("rst_ovf", 32'(err_overflow), 32'h0);
    check("rst_unf", 32'(err_underflow), 32'h0);

    // Three words into flux 0, popped back-to-back
    wr(1'b0, 32'h11);
    wr(1'b0, 32'h22);
    wr(1'b0, 32'h33);
    check("f0_empty", 32'(rp.empty), 32'h2);
    check("f0_dout0", rp.dout, 32'h11);
    rp.read = 2'b01;
    tick();
    check("f0_dout1", rp.dout, 32'h22);
    tick();
    check("f0_dout2", rp.dout, 32'h33);
    tick();
    rp.read = '0;
    check("f0_drained_empty", 32'(rp.empty), 32'h3);
    check("f0_drained_dout", rp.dout, 32'h0);
    check("f0_no_unf", 32'(err_underflow), 32'h0);

    // Fill flux 1, overflow on the 9th write
    for (int k = 0; k < DEPTH; k++) wr(1'b1, 32'h100 + 32'(k));
    wr_tag = 1'b1;
    #1;
    check("f1_full_tag1", 32'(wp.full), 32'h1);
    wr_tag = 1'b0;
    #1;
    check("f1_full_tag0", 32'(wp.full), 32'h0);
    check("pre_ovf", 32'(err_overflow), 32'h0);
    wr(1'b1, 32'hDEAD);
    check("ovf_set", 32'(err_overflow), 32'h1);
    check("f1_head", rp.dout, 32'h100);

    // Write+read on a full flux: write rejected, count drops to 7
    wr_tag   = 1'b1;
    wp.din   = 32'hBEEF;
    wp.write = 1'b1;
    rp.read  = 2'b10;
    tick();
    idle();
    check("f1_full_after_rw", 32'(wp.full), 32'h0);
    for (int k = 1; k < DEPTH; k++) begin
      check($sformatf("f1_drain%0d", k), rp.dout, 32'h100 + 32'(k));
      rd(2'b10);
    end
    check("f1_drained_empty", 32'(rp.empty), 32'h3);

    // Priority: flux 1 presented over flux 0
    wr(1'b0, 32'hA0);
    wr(1'b1, 32'hB0);
    check("prio_empty", 32'(rp.empty), 32'h0);
    check("prio_dout_b0", rp.dout, 32'hB0);
    rd(2'b10);
    check("prio_dout_a0", rp.dout, 32'hA0);
    check("prio_empty2", 32'(rp.empty), 32'h2);
    rd(2'b01);
    check("prio_drained", 32'(rp.empty), 32'h3);

    // Steady write+read on half-full flux 0 across pointer wrap
    for (int k = 0; k < 4; k++) wr(1'b0, 32'hC0 + 32'(k));
    for (int k = 0; k < 20; k++) begin
      check($sformatf("steady%0d", k), rp.dout, 32'hC0 + 32'(k));
      wr_tag   = 1'b0;
      wp.din   = 32'hC4 + 32'(k);
      wp.write = 1'b1;
      rp.read  = 2'b01;
      tick();
    end
    idle();
    for (int k = 20; k < 24; k++) begin
      check($sformatf("steady_drain%0d", k), rp.dout, 32'hC0 + 32'(k));
      rd(2'b01);
    end
    check("steady_empty", 32'(rp.empty), 32'h3);
    check("steady_no_unf", 32'(err_underflow), 32'h0);

    // Illegal reads
    wr(1'b0, 32'h55);
    rd(2'b10);
    check("unf_f1_empty_set", 32'(err_underflow), 32'h1);
    check("unf_f1_empty_dout", rp.dout, 32'h55);
    check("unf_f1_empty_state", 32'(rp.empty), 32'h2);
    wr(1'b1, 32'h66);
    rd(2'b01);
    check("unf_nonsel_dout", rp.dout, 32'h66);
    check("unf_nonsel_state", 32'(rp.empty), 32'h0);
    rd(2'b11);
    check("unf_multi_dout", rp.dout, 32'h66);
    check("unf_multi_state", 32'(rp.empty), 32'h0);
    check("ovf_sticky", 32'(err_overflow), 32'h1);

    // Reset mid-stream, with a write held during reset
    rst      = 1'b1;
    wr_tag   = 1'b0;
    wp.din   = 32'h77;
    wp.write = 1'b1;
    tick();
    check("mid_rst_empty", 32'(rp.empty), 32'h3);
    check("mid_rst_dout", rp.dout, 32'h0);
    check("mid_rst_ovf", 32'(err_overflow), 32'h0);
    check("mid_rst_unf", 32'(err_underflow), 32'h0);
    rst = 1'b0;
    idle();
    tick();
    check("post_rst_empty", 32'(rp.empty), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
